// File: rtl/mul_stage_pkg.sv
// Shared types and constants for the multiplier Z-register sequencer.
package mul_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SEND_LO = 2'd2,
    ST_SEND_HI = 2'd3
  } state_t;

  localparam logic BEAT_LO = 1'b0;
  localparam logic BEAT_HI = 1'b1;

  localparam int DEF_SETTLE_CYCLES = 2;
  // Settle counter is sized for the largest legal window (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/z_reg_pair.sv
// HI/LO product capture register with load enable and registered zero flag.
module z_reg_pair #(
  parameter int BITS = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load,
  input  logic [2*BITS-1:0] d,
  output logic [BITS-1:0]   zhi,
  output logic [BITS-1:0]   zlo,
  output logic              zero
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      zhi  <= '0;
      zlo  <= '0;
      zero <= 1'b0;
    end else if (load) begin
      {zhi, zlo} <= d;
      zero       <= (d == '0);
    end
  end

endmodule

// File: rtl/mul_zreg_sequencer.sv
// Latches operands for the external Booth multiplier, waits out its settle
// window, captures the product and returns it as LO then HI bus beats.
//
// state      | meaning
// IDLE       | waiting for start; operands hold last accepted values
// SETTLE     | counting down the multiplier multicycle window
// SEND_LO    | presenting product low word, waiting for ready
// SEND_HI    | presenting product high word, done on ready
module mul_zreg_sequencer
  import mul_stage_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [BITS-1:0]   op_a,
  input  logic [BITS-1:0]   op_b,
  output logic [BITS-1:0]   mul_a,
  output logic [BITS-1:0]   mul_b,
  input  logic [2*BITS-1:0] product_in,
  output logic [BITS-1:0]   bus_data,
  output logic              bus_hi,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              busy,
  output logic              zero,
  output logic              done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic [BITS-1:0]  zhi;
  logic [BITS-1:0]  zlo;

  assign load = (state == ST_SETTLE) && (cnt == '0);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mul_a <= '0;
      mul_b <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mul_a <= op_a;
            mul_b <= op_b;
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_SEND_LO;
          else           cnt   <= cnt - CNT_W'(1);
        end
        ST_SEND_LO: begin
          if (bus_ready) state <= ST_SEND_HI;
        end
        ST_SEND_HI: begin
          if (bus_ready) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  z_reg_pair #(.BITS(BITS)) u_zreg (
    .clock (clock),
    .clear (clear),
    .load  (load),
    .d     (product_in),
    .zhi   (zhi),
    .zlo   (zlo),
    .zero  (zero)
  );

  always_comb begin
    busy      = (state != ST_IDLE);
    bus_valid = 1'b0;
    bus_hi    = BEAT_LO;
    bus_data  = '0;
    if (state == ST_SEND_LO) begin
      bus_valid = 1'b1;
      bus_data  = zlo;
    end else if (state == ST_SEND_HI) begin
      bus_valid = 1'b1;
      bus_hi    = BEAT_HI;
      bus_data  = zhi;
    end
  end

endmodule

// File: doc/mul_zreg_sequencer.md
# mul_zreg_sequencer

Sequential wrapper sitting between the datapath bus and the combinational Booth `multiply` module. It latches operands and drives them to the multiplier, then waits a fixed settle window that covers the multiplier's multicycle path. It captures the 64-bit product into a Z register pair and returns it to the bus as two valid/ready beats, LO then HI.

## Interface
- `BITS`, 32, operand width; the product is `2*BITS`.
- `SETTLE_CYCLES`, 2, number of cycles the multiplier output is allowed to settle; legal range 1..15.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a multiply; sampled only in IDLE.
- `op_a`  in  BITS  multiplicand (two's complement).
- `op_b`  in  BITS  multiplier (two's complement).
- `mul_a`  out  BITS  latched multiplicand, wired to `multiply.multiplicand`.
- `mul_b`  out  BITS  latched multiplier, wired to `multiply.multiplier`.
- `product_in`  in  2*BITS  `multiply.outputMul`.
- `bus_data`  out  BITS  result beat.
- `bus_hi`  out  1  0 = LO beat, 1 = HI beat.
- `bus_valid`  out  1  beat present.
- `bus_ready`  in  1  consumer accepts the beat.
- `busy`  out  1  state is not IDLE.
- `zero`  out  1  captured product is all zeros.
- `done`  out  1  one-cycle pulse after the HI beat is accepted.

## Operation
- States: IDLE, SETTLE, SEND_LO, SEND_HI.
- **IDLE**
  - On `start`: latch `op_a`/`op_b` into `mul_a`/`mul_b`, load `cnt = SETTLE_CYCLES-1`, and go to SETTLE.
  - Without `start`: hold.
- **SETTLE**
  - If `cnt == 0`: set `{zhi,zlo} <= product_in` and `zero <= (product_in == 0)`, then go to SEND_LO.
  - Else: decrement `cnt`.
  - `start` is ignored.
- **SEND_LO**
  - Outputs: `bus_valid = 1`, `bus_data = zlo`, `bus_hi = 0`.
  - On `bus_ready`: go to SEND_HI.
  - Otherwise hold indefinitely, with data stable.
- **SEND_HI**
  - Outputs: `bus_valid = 1`, `bus_data = zhi`, `bus_hi = 1`.
  - On `bus_ready`: go to IDLE and set `done <= 1` for exactly one cycle.
- Outside SEND states: `bus_valid = 0` and `bus_data = 0`.
- `busy`, `bus_valid`, `bus_hi` and `bus_data` are decoded combinationally from the state and Z registers. `done`, `zero`, the Z registers, `mul_a` and `mul_b` are registered.
- `mul_a`/`mul_b` hold their values until the next accepted `start`. They are never changed during SETTLE or SEND.
- `start` is accepted in the same cycle that `done` is high, because the state is already IDLE. This gives back-to-back operation.
- Reset, asserted at any time including mid-transfer:
  - state goes to IDLE;
  - `cnt`, `zhi`, `zlo`, `mul_a`, `mul_b`, `zero` and `done` go to 0;
  - the in-flight result is discarded and no `done` is produced.
- Width rule: the product is stored as delivered by the multiplier. There is no truncation and no re-signing.

## Timing
- Reset values: `busy = 0`, `bus_valid = 0`, `bus_data = 0`, `bus_hi = 0`, `done = 0`, `zero = 0`, `mul_a = 0`, `mul_b = 0`.
- Let edge E0 be the edge where `start` is accepted.
  - Capture occurs at edge E(SETTLE_CYCLES).
  - The LO beat is valid from that edge.
  - With `bus_ready` held high: LO transfers at E(S+1), HI transfers at E(S+2), and `done` is high in the cycle after E(S+2).
  - Minimum start-to-done: `SETTLE_CYCLES + 3` cycles.
- `bus_valid` never deasserts without a handshake. `bus_data` and `bus_hi` are stable while `valid && !ready`.

## Structure
- Shared package `mul_stage_pkg`:
  - state enum (IDLE/SETTLE/SEND_LO/SEND_HI, 2 bits);
  - `BEAT_LO`/`BEAT_HI` constants;
  - default `SETTLE_CYCLES`.
- The top module holds the FSM, counter, and operand latches.
- Sub-module `z_reg_pair`: 64-bit HI/LO capture register with async `clear`, load enable, and zero detect.
- `multiply` is instantiated by the parent, not inside this block.

## Test plan
- **Unsigned-looking multiply:** `op_a = 7`, `op_b = 6`, `start`, `ready = 1` -> LO beat `0x0000002A` with `bus_hi = 0`, then HI beat `0x00000000` with `bus_hi = 1`; `done` pulses once; `zero = 0`.
- **Signed multiply:** `op_a = -3` (`0xFFFFFFFD`), `op_b = 5` -> LO `0xFFFFFFF1`, HI `0xFFFFFFFF`.
- **Backpressure:** hold `bus_ready = 0` for 5 cycles in SEND_LO -> `bus_valid` stays 1 and LO data stays stable; release -> HI follows; `start` pulses during busy are ignored and `mul_a` is unchanged.
- **Zero and back-to-back:** `op_b = 0` -> `zero = 1` and both beats 0. Assert `start` in the `done` cycle with `0x10000 × 0x10000` -> accepted immediately; LO `0x00000000`, HI `0x00000001`.
- **Reset mid-operation:** assert `clear` asynchronously during SETTLE and again during SEND_HI -> outputs are immediately at reset values, with no `done` and no further beats.
- **Settle parameter sweep:** `SETTLE_CYCLES = 1` and `15` -> first `bus_valid` appears exactly S edges after the start edge.
